// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter that sequences single-word accesses to the s_ram block.
// Each grant runs IDLE -> ACCESS -> CAPTURE -> RESP; out-of-range addresses get an error ack and no strobe.
module sram_arbiter #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8,
    parameter int MEM_SIZE  = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 we_a,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [WORD_SIZE-1:0] wdata_a,
    input  logic [WORD_SIZE-1:0] wdata_b,
    output logic                 ack_a,
    output logic                 ack_b,
    output logic [WORD_SIZE-1:0] rdata_a,
    output logic [WORD_SIZE-1:0] rdata_b,
    output logic                 err_a,
    output logic                 err_b,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_din,
    output logic                 ram_wr,
    output logic                 ram_cs,
    input  logic [WORD_SIZE-1:0] ram_dout,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t               state_q;
    logic                 last_b_q;   // 1 = B was served last, so A wins the next tie
    logic                 gnt_b_q;
    logic                 we_q;
    logic                 oor_q;
    logic [ADDR_SIZE-1:0] ram_addr_q;
    logic [WORD_SIZE-1:0] ram_din_q;
    logic                 ram_cs_q;
    logic                 ram_wr_q;
    logic                 ack_a_q;
    logic                 ack_b_q;
    logic                 err_a_q;
    logic                 err_b_q;
    logic [WORD_SIZE-1:0] rdata_a_q;
    logic [WORD_SIZE-1:0] rdata_b_q;

    logic                 pick_b_d;
    logic                 we_d;
    logic                 oor_d;
    logic [ADDR_SIZE-1:0] addr_d;
    logic [WORD_SIZE-1:0] wdata_d;
    logic [WORD_SIZE-1:0] cap_d;

    always_comb begin
        pick_b_d = req_b && (!req_a || !last_b_q);
        we_d     = pick_b_d ? we_b    : we_a;
        addr_d   = pick_b_d ? addr_b  : addr_a;
        wdata_d  = pick_b_d ? wdata_b : wdata_a;
        oor_d    = (addr_d >= ADDR_SIZE'(MEM_SIZE));
        cap_d    = oor_q ? '0 : ram_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            gnt_b_q    <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_cs_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        gnt_b_q    <= pick_b_d;
                        last_b_q   <= pick_b_d;
                        we_q       <= we_d;
                        oor_q      <= oor_d;
                        ram_addr_q <= addr_d;
                        ram_din_q  <= wdata_d;
                        ram_cs_q   <= !oor_d;
                        ram_wr_q   <= we_d && !oor_d;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_cs_q <= 1'b0;
                    ram_wr_q <= 1'b0;
                    state_q  <= CAPTURE;
                end
                CAPTURE: begin
                    // Writes leave the requester's read-data register untouched.
                    if (!we_q) begin
                        if (gnt_b_q) begin
                            rdata_b_q <= cap_d;
                        end else begin
                            rdata_a_q <= cap_d;
                        end
                    end
                    ack_a_q <= !gnt_b_q;
                    ack_b_q <= gnt_b_q;
                    err_a_q <= !gnt_b_q && oor_q;
                    err_b_q <= gnt_b_q && oor_q;
                    state_q <= RESP;
                end
                RESP: begin
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
                    err_a_q <= 1'b0;
                    err_b_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_cs   = ram_cs_q;
    assign ram_wr   = ram_wr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a list-level model predicts grant order, responses and RAM strobes,
// and a monitor compares them against the DUT and a behavioural s_ram.
module tb_sram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MS = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          ack_a, ack_b, err_a, err_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wr, ram_cs, busy;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .err_a(err_a), .err_b(err_b),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr), .ram_cs(ram_cs),
        .ram_dout(ram_dout), .busy(busy)
    );

    // Behavioural s_ram: synchronous write, registered read, both qualified by cs.
    logic [DW-1:0] ram_mem [MS];
    always @(posedge clk) begin
        if (ram_cs && (int'(ram_addr) < MS)) begin
            if (ram_wr) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } tx_t;
    typedef struct packed { logic port_b; logic err; logic [DW-1:0] rdata; } resp_t;
    typedef struct packed { logic [AW-1:0] addr; logic wr; logic [DW-1:0] din; } strobe_t;

    tx_t     txa[$];
    tx_t     txb[$];
    resp_t   exp_q[$];
    strobe_t strb_q[$];

    logic [DW-1:0] m_mem [MS];
    logic          m_last_b = 1'b1;
    logic [DW-1:0] m_rd_a = '0, m_rd_b = '0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Reference schedule: both lists are pending from the start and each port holds req until its
    // list is exhausted, so grants alternate from the favoured port while both have work left.
    task automatic model_batch();
        int ia = 0;
        int ib = 0;
        while (ia < txa.size() || ib < txb.size()) begin
            logic  pick_b;
            logic  oor;
            tx_t   t;
            resp_t r;
            if (ia < txa.size() && ib < txb.size()) pick_b = !m_last_b;
            else                                    pick_b = (ib < txb.size());
            if (pick_b) begin t = txb[ib]; ib++; end
            else        begin t = txa[ia]; ia++; end
            oor      = (int'(t.addr) >= MS);
            r.port_b = pick_b;
            r.err    = oor;
            if (t.we)     r.rdata = pick_b ? m_rd_b : m_rd_a;
            else if (oor) r.rdata = '0;
            else          r.rdata = m_mem[t.addr];
            if (!t.we) begin
                if (pick_b) m_rd_b = r.rdata;
                else        m_rd_a = r.rdata;
            end
            if (!oor) begin
                strb_q.push_back({t.addr, t.we, t.wdata});
                if (t.we) m_mem[t.addr] = t.wdata;
            end
            exp_q.push_back(r);
            m_last_b = pick_b;
        end
    endtask

    task automatic present_a(input tx_t t);
        req_a = 1'b1; we_a = t.we; addr_a = t.addr; wdata_a = t.wdata;
    endtask

    task automatic present_b(input tx_t t);
        req_b = 1'b1; we_b = t.we; addr_b = t.addr; wdata_b = t.wdata;
    endtask

    task automatic run_batch();
        int ia = 0;
        int ib = 0;
        int na = txa.size();
        int nb = txb.size();
        int bound = 8 * (na + nb) + 20;
        model_batch();
        @(negedge clk);
        if (na > 0) present_a(txa[0]);
        if (nb > 0) present_b(txb[0]);
        while (ia < na || ib < nb) begin
            @(negedge clk);
            if (ack_a && ia < na) begin
                ia++;
                if (ia < na) present_a(txa[ia]);
                else         req_a = 1'b0;
            end
            if (ack_b && ib < nb) begin
                ib++;
                if (ib < nb) present_b(txb[ib]);
                else         req_b = 1'b0;
            end
            bound--;
            if (bound == 0) begin
                fail_now("batch_timeout");
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        txa.delete();
        txb.delete();
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_rd_a   = '0;
        m_rd_b   = '0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic tx_t mk(input logic we, input int addr, input int data);
        tx_t t;
        t.we = we; t.addr = AW'(addr); t.wdata = DW'(data);
        return t;
    endfunction

    function automatic tx_t rand_tx();
        tx_t t;
        int  r = int'($urandom_range(0, 19));
        t.we = 1'($urandom_range(0, 1));
        if (r == 0)      t.addr = AW'(1023);
        else if (r == 1) t.addr = AW'(MS);
        else if (r == 2) t.addr = AW'($urandom_range(MS, 1022));
        else             t.addr = AW'($urandom_range(0, MS - 1));
        t.wdata = DW'($urandom);
        return t;
    endfunction

    // Monitor: samples just after each rising edge and checks against the scoreboard queues.
    initial begin : monitor
        int            busy_cnt;
        logic [DW-1:0] trk_a;
        logic [DW-1:0] trk_b;
        resp_t         e;
        strobe_t       s;
        busy_cnt = 0; trk_a = '0; trk_b = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_ack_a", ack_a, 0);     check("rst_ack_b", ack_b, 0);
                check("rst_err_a", err_a, 0);     check("rst_err_b", err_b, 0);
                check("rst_rdata_a", rdata_a, 0); check("rst_rdata_b", rdata_b, 0);
                check("rst_ram_addr", ram_addr, 0); check("rst_ram_din", ram_din, 0);
                check("rst_ram_wr", ram_wr, 0);   check("rst_ram_cs", ram_cs, 0);
                check("rst_busy", busy, 0);
                busy_cnt = 0; trk_a = '0; trk_b = '0;
            end else begin
                busy_cnt = busy ? busy_cnt + 1 : 0;
                check("wr_without_cs", ram_wr & ~ram_cs, 0);
                if (ram_cs) begin
                    check("cs_slot", busy_cnt, 1);
                    if (strb_q.size() == 0) fail_now("unexpected_ram_strobe");
                    else begin
                        s = strb_q.pop_front();
                        check("strobe_addr", ram_addr, s.addr);
                        check("strobe_wr", ram_wr, s.wr);
                        check("strobe_din", ram_din, s.din);
                    end
                end
                if (ack_a || ack_b) begin
                    check("ack_both", ack_a & ack_b, 0);
                    check("ack_latency", busy_cnt, 3);
                    if (exp_q.size() == 0) fail_now("unexpected_ack");
                    else begin
                        e = exp_q.pop_front();
                        check("ack_port", ack_b, e.port_b);
                        check("ack_err", e.port_b ? err_b : err_a, e.err);
                        check("ack_rdata", e.port_b ? rdata_b : rdata_a, e.rdata);
                        if (e.port_b) trk_b = e.rdata;
                        else          trk_a = e.rdata;
                        $display("txn port=%s err=%0d rdata=0x%02h t=%0t",
                                 ack_b ? "B" : "A", ack_b ? err_b : err_a,
                                 ack_b ? rdata_b : rdata_a, $time);
                    end
                end
                if (!ack_a) check("rdata_a_hold", rdata_a, trk_a);
                if (!ack_b) check("rdata_b_hold", rdata_b, trk_b);
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single write then read on A.
        txa.push_back(mk(1'b1, 7, 14)); run_batch();
        txa.push_back(mk(1'b0, 7, 0));  run_batch();
        check("t1_rdata_a", rdata_a, 14);

        // Fill and read back through B with req held throughout.
        for (int k = 0; k < MS; k++) txb.push_back(mk(1'b1, k, 2 * k));
        for (int k = 0; k < MS; k++) txb.push_back(mk(1'b0, k, k + 1));
        run_batch();
        check("fill_last_rdata_b", rdata_b, 98);

        // Simultaneous requests straight out of reset.
        rst_pulse();
        for (int k = 0; k < 4; k++) begin
            txa.push_back(mk(1'b0, 10 + k, 0));
            txb.push_back(mk(1'b0, 20 + k, 0));
        end
        run_batch();

        // Out of range then boundary-valid.
        txa.push_back(mk(1'b0, 50, 0));
        txa.push_back(mk(1'b1, 1023, 8'h55));
        txa.push_back(mk(1'b0, 49, 0));
        run_batch();
        check("oor_follow_rdata_a", rdata_a, 98);

        // Reset during CAPTURE of a B read.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; addr_b = AW'(5); wdata_b = 8'h3C;
        strb_q.push_back({AW'(5), 1'b0, 8'h3C});
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_capture", busy, 1);
        rst = 1'b1; req_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_no_ack_b", ack_b, 0);
        check("mid_idle", busy, 0);
        txb.push_back(mk(1'b0, 5, 0)); run_batch();
        txa.push_back(mk(1'b0, 6, 0)); txb.push_back(mk(1'b0, 7, 0)); run_batch();

        // Pointer restore: A served last, reset in IDLE, A must still win the tie.
        txa.push_back(mk(1'b0, 1, 0)); run_batch();
        rst_pulse();
        txa.push_back(mk(1'b0, 2, 0)); txb.push_back(mk(1'b0, 3, 0)); run_batch();

        // Write isolation: A writes addr 3 while B holds a read of addr 3.
        txb.push_back(mk(1'b0, 10, 0)); run_batch();
        txa.push_back(mk(1'b1, 3, 8'hAA)); txb.push_back(mk(1'b0, 3, 0)); run_batch();
        check("iso_rdata_b", rdata_b, 8'hAA);
        check("iso_rdata_a", rdata_a, 4);

        // Randomized batches.
        for (int n = 0; n < 40; n++) begin
            int na = int'($urandom_range(0, 3));
            int nb = int'($urandom_range(0, 3));
            for (int k = 0; k < na; k++) txa.push_back(rand_tx());
            for (int k = 0; k < nb; k++) txb.push_back(rand_tx());
            run_batch();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("strobe_q_drained", strb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Synchronous two-port arbiter and sequencer for the `s_ram` block (10-bit address, 8-bit word, 50 words). It accepts read/write requests from two independent requesters (A and B) and grants them round-robin. It drives the RAM's `addr`, `d_in`, `wr` and `cs` pins with a fixed, glitch-free access sequence, captures `d_out`, and returns read data with a one-cycle acknowledge. Addresses outside the populated RAM are rejected with an error response and no RAM access.

## Interface
- `ADDR_SIZE`, 10, address width; matches the RAM address width.
- `WORD_SIZE`, 8, data width; matches the RAM word width.
- `MEM_SIZE`, 50, number of populated words; a valid address satisfies addr < MEM_SIZE.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_a`, `req_b`  input  1  access request; held high until the matching ack.
- `we_a`, `we_b`  input  1  1 = write, 0 = read; stable while req is high.
- `addr_a`, `addr_b`  input  ADDR_SIZE  word address; stable while req is high.
- `wdata_a`, `wdata_b`  input  WORD_SIZE  write data; stable while req is high.
- `ack_a`, `ack_b`  output  1  one-cycle completion pulse.
- `rdata_a`, `rdata_b`  output  WORD_SIZE  read data; valid while ack is high, then held until the next ack to that port.
- `err_a`, `err_b`  output  1  out-of-range flag; valid only with ack.
- `ram_addr`  output  ADDR_SIZE  to RAM `addr`.
- `ram_din`  output  WORD_SIZE  to RAM `d_in`.
- `ram_wr`  output  1  to RAM `wr`.
- `ram_cs`  output  1  to RAM `cs`.
- `ram_dout`  input  WORD_SIZE  from RAM `d_out`.
- `busy`  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → ACCESS → CAPTURE → RESP → IDLE. All transitions are unconditional except the one out of IDLE.
- **IDLE**: samples `req_a` and `req_b`.
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port not served last, using a 1-bit `last` pointer. After reset the pointer favours A.
  - On grant: register the granted port's addr, wdata and we; record the port ID; update `last`; go to ACCESS.
- **Range check**: done on the registered address at grant. If addr ≥ MEM_SIZE, set the internal `oor` flag.
- **ACCESS**:
  - `ram_addr` = latched address; `ram_din` = latched wdata.
  - `ram_cs` = !oor.
  - `ram_wr` = we & !oor.
- **CAPTURE**:
  - `ram_cs` = 0 and `ram_wr` = 0.
  - `ram_addr` and `ram_din` are held.
  - At the end of the cycle, capture `ram_dout` into the granted port's rdata register, but only for a read with !oor.
  - For an oor read, load 0 into rdata instead.
  - A write leaves that port's rdata unchanged.
- **RESP**:
  - Granted port's ack = 1; its err = oor.
  - The other port's ack and err are 0.
  - Requests are not sampled in this state.
- The requester deasserts req (or presents a new request) on the edge where it observes ack. A req still high in the following IDLE is treated as a new request.
- Only one access is in flight at a time; the non-granted port waits with req held.
- Round-robin guarantee: with both ports requesting continuously, grants strictly alternate A, B, A, B…

## Timing
- A request seen in IDLE at edge E0 gives:
  - ACCESS during cycle E0+1;
  - CAPTURE during E0+2;
  - ack high during E0+3.
- The next grant is earliest at the IDLE sample in cycle E0+4. Peak throughput is one access per 4 cycles.
- `ram_cs` and `ram_wr` are registered outputs. They are never high outside ACCESS and are high for exactly one cycle per valid access.
- `ram_addr` and `ram_din` change only on entry to ACCESS. They are stable for the whole ACCESS and CAPTURE window.
- Reset values, and the values after `rst` in any state including mid-access:
  - state = IDLE, `last` favours A;
  - `ack_a` = `ack_b` = 0, `err_a` = `err_b` = 0;
  - `rdata_a` = `rdata_b` = 0;
  - `ram_addr` = 0, `ram_din` = 0, `ram_wr` = 0, `ram_cs` = 0;
  - `busy` = 0.
- An in-flight access aborted by reset produces no ack. Its requester must re-issue.
- Boundary addresses:
  - addr = MEM_SIZE-1 (49) is valid.
  - addr = MEM_SIZE (50) and 1023 are errors with no RAM strobe.
- A request arriving while busy is not lost: it is sampled at the next IDLE because req is held.

## Test plan
- **Single write then read (A)**: A writes addr 7, data 14. Then A reads addr 7. Expect `ram_cs` for one cycle, with `ram_wr` = 1 in the write ACCESS cycle and 0 in the read ACCESS cycle. ack at cycle +3 of each access; `rdata_a` = 14, `err_a` = 0.
- **Fill/readback**: B writes addr k with data 2k for k = 0..49, then reads all 50. Every `rdata_b` = 2k; each access takes exactly 4 cycles.
- **Simultaneous requests**: `req_a` and `req_b` rise in the same cycle out of reset and are held for 4 accesses each. Grant order is A, B, A, B, …; neither port is starved.
- **Out of range**: A reads addr 50, then writes addr 1023. `ram_cs` stays 0 throughout; ack with `err_a` = 1 and `rdata_a` = 0. A follow-up read of addr 49 gives `err_a` = 0.
- **Reset mid-access**: assert `rst` during CAPTURE of a B read. The next cycle shows all outputs 0, state IDLE and no `ack_b`. B re-requests and completes normally; A then wins the first tie, since the pointer is back to favouring A.
- **Write isolation**: A writes addr 3 with 0xAA while `req_b` (read addr 3) is held. B receives 0xAA; `rdata_a` is unchanged by the write.
